xadc_conv_scheduler: RTL and testbench
======================================

# xadc_conv_scheduler

Sequences XADC conversions on auxiliary channel VAUX6 and shares the converter between two requesters: a periodic auto-sampler and the manual conversion input (ManConv). It issues CONVST, waits for end-of-conversion, performs the DRP register read and returns a tagged 12-bit sample to the display and DAC logic. It sits between the XADC primitive and the consumers of the measured value in the monitoring datapath.

## Interface
- SAMPLE_DIV, 100000, CLK100M cycles between auto-sample ticks (1 kHz)
- DRP_ADDR, 7'h16, DRP status register address read after each conversion (VAUX6)
- TIMEOUT_CYC, 1023, max cycles in any wait state (used only with timeout feature)
- CLK100M  in  1  100 MHz clock
- RESET_N  in  1  reset; asynchronous, active-low
- man_req  in  1  manual conversion request, synchronized level; rising edge = one request
- auto_en  in  1  enables periodic tick generation
- convst  out  1  XADC conversion start pulse
- eoc  in  1  XADC end-of-conversion pulse
- den  out  1  DRP enable pulse
- dwe  out  1  DRP write enable, constant 0
- daddr  out  7  DRP address, constant DRP_ADDR
- drdy  in  1  DRP data ready
- drp_do  in  16  DRP read data
- sample  out  12  last captured result, drp_do[15:4]
- sample_valid  out  1  one-cycle pulse with new sample
- sample_src  out  1  source of sample: 0 auto, 1 manual
- busy  out  1  FSM not in IDLE
- err  out  1  sticky timeout flag

## Operation
- Tick counter: counts 0..SAMPLE_DIV-1 while auto_en=1, tick at terminal count sets auto_pend; auto_en=0 clears counter, keeps existing auto_pend.
- Manual edge detect: man_req registered; 0->1 sets man_pend.
- Pending flags are one-deep; repeated requests while pending collapse into one.
- Arbiter (IDLE only): one pending -> grant it; both pending -> grant opposite of last_src (last_src resets to auto, so manual wins first tie). Grant clears that pend flag.
- FSM: IDLE -> CONV (convst=1 one cycle) -> WAIT_EOC (until eoc) -> RD (den=1 one cycle) -> WAIT_DRDY (until drdy; capture drp_do[15:4]) -> DONE (sample_valid=1, sample_src=granted source, last_src updated) -> IDLE.
- eoc/drdy outside their wait states are ignored.
- Requests arriving in any state are pended, never lost.
- Reset values: convst=0, den=0, dwe=0, sample=0, sample_valid=0, sample_src=0, busy=0, err=0, pend flags=0, counter=0, FSM=IDLE.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous); in-flight conversion is abandoned, no sample_valid.

## Timing
- Grant in IDLE at cycle N -> convst high cycle N+1.
- eoc seen cycle M -> den high M+1.
- drdy seen cycle K -> sample updated and sample_valid high K+1.
- Minimum request-to-sample_valid: 5 cycles plus XADC latencies.
- Back-to-back: next grant evaluated in first IDLE cycle after DONE.
- Tick and manual edge in same cycle: both pend; arbiter tie rule applies.

## Configuration
- XADC_SCHED_TIMEOUT_EN defined: wait counter runs in WAIT_EOC and WAIT_DRDY; reaching TIMEOUT_CYC sets err (sticky until reset), returns to IDLE, no sample_valid, last_src unchanged, granted request dropped.
- Not defined: waits are unbounded, err tied 0, no wait counter logic.

## Structure
- Package xadc_sched_pkg: state enum (IDLE, CONV, WAIT_EOC, RD, WAIT_DRDY, DONE), source typedef (SRC_AUTO=0, SRC_MAN=1), default DRP_ADDR constant.
- One sub-module: xadc_sched_arb (two pend flags, last_src, grant logic); tick counter and FSM stay in top.

## Test plan
- Manual only: auto_en=0, man_req edge, eoc 20 cycles after convst, drdy 3 cycles after den with drp_do=16'hABC0 -> sample=12'hABC, sample_src=1, one sample_valid pulse.
- Auto: SAMPLE_DIV=50, auto_en=1, fixed model latencies -> convst every 50 cycles, sample_src=0 each time.
- Tie: tick and man_req edge same cycle -> manual sample first, auto sample immediately after; second tie -> auto first.
- Request during busy: three man_req edges during WAIT_EOC -> exactly one extra conversion afterward.
- Timeout (macro on, TIMEOUT_CYC=15): eoc never returned -> err=1 after 15 cycles in WAIT_EOC, busy=0, no sample_valid; next request proceeds normally.
- Reset mid-op: RESET_N low in WAIT_DRDY -> den/convst/busy/sample_valid 0 without clock edge; after release no stale sample_valid.

Source files
------------

// File: rtl/xadc_sched_pkg.sv
// xadc_sched_pkg: shared types and default constants for the XADC
// conversion scheduler (state encoding, request source, DRP address).
package xadc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONV      = 3'd1,
        WAIT_EOC  = 3'd2,
        RD        = 3'd3,
        WAIT_DRDY = 3'd4,
        DONE      = 3'd5
    } state_e;

    typedef enum logic {
        SRC_AUTO = 1'b0,
        SRC_MAN  = 1'b1
    } src_e;

    localparam logic [6:0]  DRP_ADDR_DEF    = 7'h16;
    localparam int unsigned SAMPLE_DIV_DEF  = 100000;
    localparam int unsigned TIMEOUT_CYC_DEF = 1023;

endpackage

// File: rtl/xadc_sched_arb.sv
// xadc_sched_arb: one-deep request flags for the auto tick and the manual
// edge, granted in IDLE with alternating priority when both are pending.
module xadc_sched_arb
    import xadc_sched_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic man_rise_i,
    input  logic idle_i,
    input  logic done_i,
    input  src_e done_src_i,
    output logic grant_o,
    output src_e grant_src_o
);

    logic auto_pend_q, auto_pend_d;
    logic man_pend_q, man_pend_d;
    src_e last_src_q, last_src_d;

    always_comb begin
        grant_o     = idle_i && (auto_pend_q || man_pend_q);
        grant_src_o = SRC_AUTO;
        if (auto_pend_q && man_pend_q) begin
            grant_src_o = (last_src_q == SRC_AUTO) ? SRC_MAN : SRC_AUTO;
        end else if (man_pend_q) begin
            grant_src_o = SRC_MAN;
        end
    end

    // New requests win over the clear so nothing arriving on a grant is lost
    always_comb begin
        auto_pend_d = auto_pend_q;
        man_pend_d  = man_pend_q;
        last_src_d  = last_src_q;
        if (grant_o && (grant_src_o == SRC_AUTO)) begin
            auto_pend_d = 1'b0;
        end
        if (grant_o && (grant_src_o == SRC_MAN)) begin
            man_pend_d = 1'b0;
        end
        if (tick_i) begin
            auto_pend_d = 1'b1;
        end
        if (man_rise_i) begin
            man_pend_d = 1'b1;
        end
        if (done_i) begin
            last_src_d = done_src_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            auto_pend_q <= 1'b0;
            man_pend_q  <= 1'b0;
            last_src_q  <= SRC_AUTO;
        end else begin
            auto_pend_q <= auto_pend_d;
            man_pend_q  <= man_pend_d;
            last_src_q  <= last_src_d;
        end
    end

endmodule

// File: rtl/xadc_conv_scheduler.sv
// xadc_conv_scheduler: shares the XADC VAUX6 converter between a periodic
// auto-sampler and manual requests. Optional: XADC_SCHED_TIMEOUT_EN.
module xadc_conv_scheduler
    import xadc_sched_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV  = SAMPLE_DIV_DEF,
    parameter logic [6:0]  DRP_ADDR    = DRP_ADDR_DEF
`ifdef XADC_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic        CLK100M,
    input  logic        RESET_N,
    input  logic        man_req,
    input  logic        auto_en,
    output logic        convst,
    input  logic        eoc,
    output logic        den,
    output logic        dwe,
    output logic [6:0]  daddr,
    input  logic        drdy,
    input  logic [15:0] drp_do,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        sample_src,
    output logic        busy,
    output logic        err
);

    localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic          man_q;
    logic          man_rise;
    logic          grant;
    src_e          grant_src;
    src_e          src_q, src_d;
    logic          capture;
    logic [11:0]   sample_q, sample_d;
    src_e          sample_src_q, sample_src_d;
    logic          timeout;
    logic          unused_lsb;

    assign unused_lsb = ^drp_do[3:0];
    assign man_rise   = man_req && !man_q;

    always_comb begin
        cnt_d = '0;
        tick  = 1'b0;
        if (auto_en) begin
            tick  = (cnt_q == CNT_MAX);
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    xadc_sched_arb u_arb (
        .clk_i       (CLK100M),
        .rst_ni      (RESET_N),
        .tick_i      (tick),
        .man_rise_i  (man_rise),
        .idle_i      (state_q == IDLE),
        .done_i      (state_q == DONE),
        .done_src_i  (src_q),
        .grant_o     (grant),
        .grant_src_o (grant_src)
    );

`ifdef XADC_SCHED_TIMEOUT_EN
    localparam int unsigned WCW = $clog2(TIMEOUT_CYC + 1);

    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           err_q, err_d;
    logic           in_wait;
    logic           wait_evt;

    // An event landing on the last wait cycle still completes normally
    always_comb begin
        in_wait  = (state_q == WAIT_EOC) || (state_q == WAIT_DRDY);
        wait_evt = ((state_q == WAIT_EOC) && eoc) ||
                   ((state_q == WAIT_DRDY) && drdy);
        timeout  = in_wait && !wait_evt &&
                   (wcnt_q == WCW'(TIMEOUT_CYC - 1));
        wcnt_d   = '0;
        if (in_wait && !wait_evt && !timeout) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        err_d = err_q || timeout;
    end

    always_ff @(posedge CLK100M or negedge RESET_N) begin
        if (!RESET_N) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge CLK100M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant) state_d = CONV;
            end
            CONV: state_d = WAIT_EOC;
            WAIT_EOC: begin
                if (eoc) state_d = RD;
                else if (timeout) state_d = IDLE;
            end
            RD: state_d = WAIT_DRDY;
            WAIT_DRDY: begin
                if (drdy) state_d = DONE;
                else if (timeout) state_d = IDLE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        convst       = (state_q == CONV);
        den          = (state_q == RD);
        sample_valid = (state_q == DONE);
        busy         = (state_q != IDLE);
    end

    always_comb begin
        capture      = (state_q == WAIT_DRDY) && drdy;
        src_d        = grant ? grant_src : src_q;
        sample_d     = capture ? drp_do[15:4] : sample_q;
        sample_src_d = capture ? src_q : sample_src_q;
    end

    always_ff @(posedge CLK100M or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q        <= '0;
            man_q        <= 1'b0;
            src_q        <= SRC_AUTO;
            sample_q     <= '0;
            sample_src_q <= SRC_AUTO;
        end else begin
            cnt_q        <= cnt_d;
            man_q        <= man_req;
            src_q        <= src_d;
            sample_q     <= sample_d;
            sample_src_q <= sample_src_d;
        end
    end

    assign dwe        = 1'b0;
    assign daddr      = DRP_ADDR;
    assign sample     = sample_q;
    assign sample_src = sample_src_q;

endmodule

// File: tb/tb_xadc_conv_scheduler.sv
// tb_xadc_conv_scheduler: directed stimulus with an XADC/DRP model and a
// scoreboard of expected samples checked by an independent monitor.
module tb_xadc_conv_scheduler;

    logic        CLK100M = 1'b0;
    logic        RESET_N = 1'b0;
    logic        man_req = 1'b0;
    logic        auto_en = 1'b0;
    logic        eoc     = 1'b0;
    logic        drdy    = 1'b0;
    logic [15:0] drp_do  = 16'h0;
    logic        convst, den, dwe, sample_valid, sample_src, busy, err;
    logic [6:0]  daddr;
    logic [11:0] sample;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int conv_n   = 0;
    logic eoc_block = 1'b0;

    typedef struct {
        logic [11:0] s;
        logic        src;
    } exp_t;

    exp_t exp_q[$];
    int   conv_log[$];

    logic [15:0] data_tab [0:12] = '{
        16'hABC0, 16'h1110, 16'h2220, 16'h3330, 16'h4440,
        16'h5550, 16'h6660, 16'h7770, 16'h8880, 16'h9990,
        16'hAAA0, 16'hBBB5, 16'hCCC0
    };

    xadc_conv_scheduler #(
        .SAMPLE_DIV  (50),
        .DRP_ADDR    (7'h16)
`ifdef XADC_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (15)
`endif
    ) dut (
        .CLK100M      (CLK100M),
        .RESET_N      (RESET_N),
        .man_req      (man_req),
        .auto_en      (auto_en),
        .convst       (convst),
        .eoc          (eoc),
        .den          (den),
        .dwe          (dwe),
        .daddr        (daddr),
        .drdy         (drdy),
        .drp_do       (drp_do),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_src   (sample_src),
        .busy         (busy),
        .err          (err)
    );

    always #5 CLK100M = ~CLK100M;
    always @(posedge CLK100M) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] s, input logic src);
        exp_t e;
        e.s   = s;
        e.src = src;
        return e;
    endfunction

    // XADC + DRP model: eoc 20 cycles after convst, drdy 3 after den
    initial begin : xadc_model
        int   eoc_cd;
        int   drdy_cd;
        logic eoc_prev;
        eoc_cd   = 0;
        drdy_cd  = 0;
        eoc_prev = 1'b0;
        forever begin
            @(negedge CLK100M);
            if (eoc_prev) chk("den_after_eoc", 32'(den), 32'd1);
            eoc  = 1'b0;
            drdy = 1'b0;
            if (!RESET_N) begin
                eoc_cd  = 0;
                drdy_cd = 0;
            end else begin
                if (eoc_cd > 0) begin
                    eoc_cd--;
                    if (eoc_cd == 0) eoc = 1'b1;
                end
                if (drdy_cd > 0) begin
                    drdy_cd--;
                    if (drdy_cd == 0) begin
                        drdy   = 1'b1;
                        drp_do = data_tab[conv_n];
                        conv_n++;
                    end
                end
                if (convst && !eoc_block) eoc_cd = 20;
                if (den) drdy_cd = 3;
            end
            eoc_prev = eoc;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK100M);
            if (convst) conv_log.push_back(cyc);
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sample: got %0h src %0b expected none",
                             sample, sample_src);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample", 32'(sample), 32'(e.s));
                    chk("sample_src", 32'(sample_src), 32'(e.src));
                end
            end
        end
    end

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge CLK100M);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s: %0d samples outstanding after %0d cycles expected 0",
                     name, exp_q.size(), budget);
        end
    endtask

    task automatic wait_hi(input int sel, input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK100M);
            n++;
        end while (((sel == 0) ? convst : den) !== 1'b1 && n < budget);
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s: strobe low for %0d cycles expected high", name, budget);
        end
    endtask

    task automatic man_edge();
        @(posedge CLK100M);
        #1 man_req = 1'b1;
        @(posedge CLK100M);
        #1 man_req = 1'b0;
    endtask

    task automatic tie();
        @(posedge CLK100M);
        #1 auto_en = 1'b1;
        repeat (49) @(posedge CLK100M);
        #1 man_req = 1'b1;
        @(posedge CLK100M);
        #1 auto_en = 1'b0;
        @(posedge CLK100M);
        #1 man_req = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;
        int n;

        repeat (3) @(negedge CLK100M);
        chk("rst_convst", 32'(convst), 32'd0);
        chk("rst_den", 32'(den), 32'd0);
        chk("rst_dwe", 32'(dwe), 32'd0);
        chk("rst_daddr", 32'(daddr), 32'h16);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_src", 32'(sample_src), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge CLK100M);
        #1 RESET_N = 1'b1;
        repeat (2) @(posedge CLK100M);

        exp_q.push_back(mk(12'hABC, 1'b1));
        #1 man_req = 1'b1;
        @(negedge CLK100M);
        chk("man_lat_c0", 32'(convst), 32'd0);
        @(negedge CLK100M);
        chk("man_lat_c1", 32'(convst), 32'd0);
        @(negedge CLK100M);
        chk("man_lat_convst", 32'(convst), 32'd1);
        chk("man_busy", 32'(busy), 32'd1);
        man_req = 1'b0;
        drain(100, "manual");

        conv_log.delete();
        @(posedge CLK100M);
        #1 auto_en = 1'b1;
        c0 = cyc;
        exp_q.push_back(mk(12'h111, 1'b0));
        exp_q.push_back(mk(12'h222, 1'b0));
        exp_q.push_back(mk(12'h333, 1'b0));
        drain(250, "auto");
        auto_en = 1'b0;
        chk("auto_conv_count", 32'(conv_log.size()), 32'd3);
        if (conv_log.size() >= 3) begin
            chk("auto_first", 32'(conv_log[0] - c0), 32'd51);
            chk("auto_period1", 32'(conv_log[1] - conv_log[0]), 32'd50);
            chk("auto_period2", 32'(conv_log[2] - conv_log[1]), 32'd50);
        end
        repeat (30) @(negedge CLK100M);

        exp_q.push_back(mk(12'h444, 1'b1));
        exp_q.push_back(mk(12'h555, 1'b0));
        tie();
        drain(150, "tie1");

        exp_q.push_back(mk(12'h666, 1'b1));
        man_edge();
        drain(100, "manual2");

        exp_q.push_back(mk(12'h777, 1'b0));
        exp_q.push_back(mk(12'h888, 1'b1));
        tie();
        drain(150, "tie2");

        exp_q.push_back(mk(12'h999, 1'b1));
        exp_q.push_back(mk(12'hAAA, 1'b1));
        man_edge();
        wait_hi(0, 20, "busy_convst");
        repeat (3) man_edge();
        drain(150, "busy_collapse");
        repeat (60) @(negedge CLK100M);

        man_edge();
        wait_hi(1, 60, "rst_den_wait");
        @(posedge CLK100M);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("async_convst", 32'(convst), 32'd0);
        chk("async_den", 32'(den), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_valid", 32'(sample_valid), 32'd0);
        chk("async_sample", 32'(sample), 32'd0);
        repeat (3) @(negedge CLK100M);
        @(posedge CLK100M);
        #1 RESET_N = 1'b1;
        repeat (40) @(negedge CLK100M);
        chk("post_rst_idle", 32'(busy), 32'd0);

        exp_q.push_back(mk(12'hBBB, 1'b1));
        man_edge();
        drain(100, "post_rst");

`ifdef XADC_SCHED_TIMEOUT_EN
        eoc_block = 1'b1;
        man_edge();
        wait_hi(0, 20, "to_convst");
        n = 0;
        while (busy && n < 40) begin
            @(negedge CLK100M);
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd16);
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);
        eoc_block = 1'b0;
        exp_q.push_back(mk(12'hCCC, 1'b1));
        man_edge();
        drain(100, "after_timeout");
        chk("err_sticky", 32'(err), 32'd1);
`else
        chk("err_tied", 32'(err), 32'd0);
`endif

        repeat (20) @(negedge CLK100M);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
